// File: rtl/dft_pkg.sv
// Shared definitions for the DFT input path: sample/address widths, run length
// defaults and the feeder FSM state encoding.
package dft_pkg;
  localparam int DFT_DATA_W  = 12;
  localparam int FEED_ADDR_W = 13;
  localparam int FEED_LEN    = 8192;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Samples that will occupy the output buffer next cycle before any pop.
  function automatic logic [1:0] feed_load(input logic [1:0] occ, input logic infl);
    return occ + {1'b0, infl};
  endfunction
endpackage

// File: rtl/dft_feed_skid.sv
// Two-entry valid/ready output buffer for the DFT feeder; the head entry drives
// the outgoing sample and occupancy is exported for the read-issue rule.
module dft_feed_skid
  import dft_pkg::*;
#(
  parameter int DATA_W = DFT_DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_pop,
  output logic [1:0]               o_occ
);
  logic signed [DATA_W-1:0] r_mem [2];
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_occ;
  logic                     w_pop;

  assign w_pop   = (r_occ != 2'd0) & i_ready;
  assign o_pop   = w_pop;
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_occ   = r_occ;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end
endmodule

// File: rtl/dft_feeder.sv
// Streams LEN stored ADC samples from a synchronous RAM into the DFT input,
// one per cycle under ready backpressure, with abort and a done pulse.
module dft_feeder
  import dft_pkg::*;
#(
  parameter int DATA_W = DFT_DATA_W,
  parameter int ADDR_W = FEED_ADDR_W,
  parameter int LEN    = FEED_LEN
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic                     o_mem_rd,
  input  logic signed [DATA_W-1:0] i_mem_rdata,
  output logic signed [DATA_W-1:0] o_data_out,
  output logic                     o_valid_out,
  input  logic                     i_ready_in,
  output logic [1:0]               o_dbg_state,
  output logic [1:0]               o_dbg_occ
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_infl;
  logic              r_done;
  logic              w_pop;
  logic [1:0]        w_occ;
  logic              w_valid;
  logic              w_mem_rd;
  logic              w_flush;
  logic              w_last_pop;

  // Handshake: a sample transfers on every cycle with valid_out & ready_in;
  // valid_out stays high and data_out stays stable until that transfer,
  // except when abort or reset empties the buffer.
  dft_feed_skid #(.DATA_W(DATA_W)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_flush),
    .i_push  (r_infl),
    .i_data  (i_mem_rdata),
    .i_ready (i_ready_in),
    .o_data  (o_data_out),
    .o_valid (w_valid),
    .o_pop   (w_pop),
    .o_occ   (w_occ)
  );

  // Load is at most 2, so a read is allowed unless the buffer would stay full.
  assign w_mem_rd   = (r_state == ST_RUN) & ((feed_load(w_occ, r_infl) != 2'd2) | w_pop);
  assign w_flush    = i_abort & (r_state != ST_IDLE);
  assign w_last_pop = (r_state == ST_FLUSH) & w_pop & (w_occ == 2'd1) & ~r_infl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_infl  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_infl <= w_mem_rd & ~w_flush;
      if (w_flush) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_state <= ST_RUN;
              r_addr  <= '0;
            end
          end
          ST_RUN: begin
            if (w_mem_rd) begin
              r_addr <= r_addr + ADDR_W'(1);
              if (r_addr == LAST_ADDR) r_state <= ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            if (w_last_pop) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = r_done;
  assign o_mem_addr  = r_addr;
  assign o_mem_rd    = w_mem_rd;
  assign o_valid_out = w_valid;
  assign o_dbg_state = r_state;
  assign o_dbg_occ   = w_occ;
endmodule

// File: doc/dft_feeder.md
# dft_feeder

- Transmitter side of the DFT input stream.
- After a `start` pulse, reads a stored acquisition of `LEN` signed ADC samples from a synchronous sample RAM and streams them, in address order, to the DFT `data_in`/`valid_in`/`ready` interface.
- Honours `ready` backpressure without losing or duplicating samples; sustains one sample per cycle while `ready` stays high.
- Sits between the acquisition RAM and the `dft` top level.

## Interface
Parameters:
- `DATA_W`, 12: sample width, matches DFT `DATA_W`.
- `ADDR_W`, 13: RAM address width.
- `LEN`, 8192: samples per run. Must satisfy 16 ≤ `LEN` ≤ 2**`ADDR_W` and be a multiple of 16.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: one-cycle run request; only honoured in IDLE.
- `abort` in 1: synchronous run cancel.
- `busy` out 1: high from the cycle after an accepted `start` until return to IDLE.
- `done` out 1: one-cycle pulse after the last sample transfers.
- `mem_addr` out `ADDR_W`: RAM read address.
- `mem_rd` out 1: RAM read enable.
- `mem_rdata` in `DATA_W` signed: RAM data, valid exactly 1 cycle after `mem_rd`.
- `data_out` out `DATA_W` signed: sample to DFT `data_in`.
- `valid_out` out 1: to DFT `valid_in`.
- `ready_in` in 1: from DFT `ready`.

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - `start`=1 → RUN. The address counter is cleared to 0.
  - `start` received in RUN or FLUSH is ignored.
- RUN:
  - `mem_rd` = (`occ` + `infl` − `pop`) < 2.
    - `occ`: 2-entry output buffer occupancy.
    - `infl`: a read was issued last cycle.
    - `pop` = `valid_out` & `ready_in`.
  - Each `mem_rd` increments the address counter.
  - After issuing address `LEN`−1 → FLUSH.
- FLUSH:
  - No reads are issued.
  - When the last sample pops, the FSM goes to IDLE and `done` pulses in the following cycle.
- Output buffer:
  - 2-entry FIFO; the head drives `data_out`; `valid_out` = (`occ` ≠ 0).
  - `mem_rdata` is pushed on the cycle after each `mem_rd`.
  - Push and pop in the same cycle are legal; `occ` stays unchanged.
  - The issue rule guarantees there is never a push into a full buffer.
- Handshake:
  - A transfer occurs on a cycle where `valid_out` & `ready_in`.
  - While `valid_out`=1 and `ready_in`=0, `data_out` is held stable.
  - `valid_out` never drops without a transfer, except on `abort` or reset.
- `abort` (any state other than IDLE):
  - Next cycle: state IDLE, buffer emptied, `valid_out`=0.
  - Any in-flight read data is discarded.
  - No `done` pulse.
  - `abort` and `start` in the same IDLE cycle: `start` wins.
- Data passes through unmodified; no width change or sign change.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rd`=0, `mem_addr`=0, `valid_out`=0, `data_out`=0, state IDLE, `occ`=0.
- Reset is asserted asynchronously and released synchronously to `clk` externally. Reset mid-run returns the block to these values immediately.
- `start` at cycle T:
  - `busy` and first `mem_rd` (addr 0) at T+1.
  - Data captured at T+2.
  - First `valid_out` at T+3.
- With `ready_in` held high: `LEN` transfers on consecutive cycles T+3 … T+2+`LEN`; `done` at T+3+`LEN`; `busy` falls the same cycle.
- `ready_in` low for k cycles while data is pending: the stream stalls k cycles and resumes at full rate with no gap caused by the stall itself.
- `mem_addr` and `mem_rd` are combinational from registered state and counts, with no path from `mem_rdata`. `ready_in` reaches `mem_rd` through one gate level.

## Structure
- Shared package `dft_pkg`:
  - `DATA_W`, `LEN`, `ADDR_W` defaults.
  - Interface widths common with `dft` (sample width 12).
- Sub-module `dft_feed_skid`:
  - 2-entry valid/ready FIFO exposing `occ`.
  - Holds the push/pop/occupancy logic.
- Top: FSM, address counter, issue rule, `abort` and `done` logic.

## Test plan
- Reset, then `start`, `ready_in`=1, RAM[i]=i−2048, `LEN`=32 → 32 transfers with values −2048…−2017, first `valid_out` at T+3, `done` at T+35, no `mem_rd` after addr 31.
- `ready_in` low for cycles 10–14 of the stream → `data_out` stable during the stall, no sample lost or repeated, total 32 transfers, `done` delayed by exactly 5 cycles.
- Random `ready_in` (50%) over `LEN`=8192 with RAM[i]=signed 12-bit LFSR → output sequence identical to RAM contents; `occ` never exceeds 2.
- `abort` at stream sample 7 → `valid_out`=0 the next cycle, `busy`=0, no `done`; a following `start` restarts from addr 0.
- `start` pulsed during RUN → ignored, address sequence uninterrupted. `rst` asserted mid-stream → all outputs 0 asynchronously, before the next clock edge.
